pe_out_collector: RTL and testbench

//  Receiving end of the PE output interface: sits below the last PE of a systolic column, captures the

---
 rtl/pe_out_collector_pkg.sv | 57 +++++
 rtl/pe_out_collector_if.sv | 31 +++
 rtl/pe_collect_fifo.sv | 70 +++++++
 rtl/pe_out_collector.sv | 111 +++++++++++
 tb/tb_pe_out_collector.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_out_collector_pkg.sv
// pe_out_collector_pkg: shared configuration, types and helpers for the PE output collector.
//   DBITS/HALF  : width of the carry-save word and of each half (carry upper, sum lower)
//   OUT_W       : signed result width delivered to the consumer
//   DEPTH       : result FIFO entries (power of two, >= 2)
//   ROWS        : results per tile; the ROWS-th result of a tile is tagged last
//   entry_t     : FIFO entry {data, last}
//   round_clip  : round-half-up arithmetic right shift followed by clip to OUT_W
// Optional feature macro: COLLECT_SAT_EN (saturate instead of wrap when narrowing to OUT_W).
package pe_out_collector_pkg;

    localparam int unsigned DBITS   = 38;
    localparam int unsigned HALF    = DBITS / 2;
    localparam int unsigned OUT_W   = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ROWS    = 4;
    localparam int unsigned SHIFT_W = 4;
    localparam int unsigned LVL_W   = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef logic phase_t;

    typedef struct packed {
        logic signed [OUT_W-1:0] data;
        logic                    last;
    } entry_t;

    // Rounding works in HALF+1 bits so adding the half-LSB bias can never wrap.
    function automatic logic signed [OUT_W-1:0] round_clip(input logic signed [HALF-1:0] v,
                                                           input logic [SHIFT_W-1:0]     shift);
        logic signed [HALF:0] ext;
        logic signed [HALF:0] bias;
        logic signed [HALF:0] r;
`ifdef COLLECT_SAT_EN
        logic signed [HALF:0] hi;
        logic signed [HALF:0] lo;
`endif
        ext  = {v[HALF-1], v};
        bias = '0;
        if (shift != '0) begin
            bias = (HALF+1)'(1) << (shift - 1'b1);
        end
        r = (ext + bias) >>> shift;
`ifdef COLLECT_SAT_EN
        hi = (HALF+1)'((2 ** (OUT_W - 1)) - 1);
        lo = ~hi;
        if (r > hi) begin
            return hi[OUT_W-1:0];
        end else if (r < lo) begin
            return lo[OUT_W-1:0];
        end
        return r[OUT_W-1:0];
`else
        return r[OUT_W-1:0];
`endif
    endfunction

endpackage

// File: rtl/pe_out_collector_if.sv
// pe_out_collector_if: PE-side input stream and consumer-side output stream of the collector.
//   in_c/in_shift/in_propagate/in_valid : registered column outputs (no backpressure)
//   out_data/out_last/out_valid/out_ready : ready/valid result stream (FIFO head)
//   ovf/level : sticky drop flag and FIFO occupancy
//   modport slave  : the collector
//   modport master : the array/consumer environment
interface pe_out_collector_if;
    import pe_out_collector_pkg::*;

    logic [DBITS-1:0]        in_c;
    logic [SHIFT_W-1:0]      in_shift;
    logic                    in_propagate;
    logic                    in_valid;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_last;
    logic                    out_valid;
    logic                    out_ready;
    logic                    ovf;
    logic [LVL_W-1:0]        level;

    modport slave (
        input  in_c, in_shift, in_propagate, in_valid, out_ready,
        output out_data, out_last, out_valid, ovf, level
    );

    modport master (
        output in_c, in_shift, in_propagate, in_valid, out_ready,
        input  out_data, out_last, out_valid, ovf, level
    );

endinterface

// File: rtl/pe_collect_fifo.sv
// pe_collect_fifo: synchronous FIFO of entry_t, Depth entries (power of two).
//   clk_i/rst_ni : clock, asynchronous active-low reset
//   push_i/wdata_i : write request (ignored when full unless a pop happens the same cycle)
//   pop_i/rdata_o  : read request / head entry (zero while empty)
//   full_o/empty_o/level_o : status
module pe_collect_fifo
    import pe_out_collector_pkg::*;
#(
    parameter int unsigned Depth = DEPTH
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  entry_t                       wdata_i,
    input  logic                         pop_i,
    output entry_t                       rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   level_o
);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned LW = $clog2(Depth + 1);

    entry_t          mem_q [Depth];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [LW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == LW'(Depth));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    // Head is forced to zero when empty so stale entries never show.
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        count_d = count_q + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/pe_out_collector.sv
// pe_out_collector: receives the registered output stream of a systolic column, resolves the
// carry-save word, rounds/shifts/clips, tags tile boundaries and buffers results in a FIFO.
//   CLK/RST_N : clock, asynchronous active-low reset
//   bus       : pe_out_collector_if.slave (input stream, output stream, ovf, level)
// Pipeline: S1 resolves sum+carry, S2 rounds/clips and tags last, FIFO write at end of S2,
// giving 3 cycles from in_valid to out_valid. The PE side cannot be stalled; a result arriving
// at a full FIFO with no pop is dropped and ovf sticks until reset.
// Optional feature macro: COLLECT_SAT_EN (saturating clip; otherwise two's-complement wrap).
module pe_out_collector
    import pe_out_collector_pkg::*;
(
    input logic               CLK,
    input logic               RST_N,
    pe_out_collector_if.slave bus
);
    logic                   s1_valid_q, s1_valid_d;
    logic signed [HALF-1:0] s1_v_q, s1_v_d;
    logic [SHIFT_W-1:0]     s1_shift_q, s1_shift_d;
    phase_t                 s1_phase_q, s1_phase_d;
    logic                   s2_valid_q, s2_valid_d;
    entry_t                 s2_entry_q, s2_entry_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    phase_t                 phase_q, phase_d;
    logic                   ovf_q, ovf_d;

    logic [CNT_W-1:0]       cnt_eff;
    logic                   fifo_full, fifo_empty;
    logic                   push, pop;
    entry_t                 head;

    // S1: carry-save resolve, mod 2^HALF.
    always_comb begin
        s1_valid_d = bus.in_valid;
        s1_v_d     = s1_v_q;
        s1_shift_d = s1_shift_q;
        s1_phase_d = s1_phase_q;
        if (bus.in_valid) begin
            s1_v_d     = bus.in_c[HALF-1:0] + bus.in_c[DBITS-1:HALF];
            s1_shift_d = bus.in_shift;
            s1_phase_d = bus.in_propagate;
        end
    end

    // S2: round/clip and tile tagging. A phase change starts a new tile at this result.
    always_comb begin
        cnt_eff    = (s1_phase_q != phase_q) ? '0 : cnt_q;
        s2_valid_d = s1_valid_q;
        s2_entry_d = s2_entry_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        if (s1_valid_q) begin
            s2_entry_d.data = round_clip(s1_v_q, s1_shift_q);
            s2_entry_d.last = (cnt_eff == CNT_W'(ROWS - 1));
            cnt_d           = s2_entry_d.last ? '0 : cnt_eff + 1'b1;
            phase_d         = s1_phase_q;
        end
    end

    assign pop  = ~fifo_empty & bus.out_ready;
    assign push = s2_valid_q & (~fifo_full | pop);

    always_comb begin
        ovf_d = ovf_q | (s2_valid_q & fifo_full & ~pop);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid_q <= 1'b0;
            s1_v_q     <= '0;
            s1_shift_q <= '0;
            s1_phase_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_entry_q <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_v_q     <= s1_v_d;
            s1_shift_q <= s1_shift_d;
            s1_phase_q <= s1_phase_d;
            s2_valid_q <= s2_valid_d;
            s2_entry_q <= s2_entry_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            ovf_q      <= ovf_d;
        end
    end

    pe_collect_fifo #(
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (push),
        .wdata_i (s2_entry_q),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (bus.level)
    );

    always_comb begin
        bus.out_valid = ~fifo_empty;
        bus.out_data  = head.data;
        bus.out_last  = head.last;
        bus.ovf       = ovf_q;
    end

endmodule

// File: tb/tb_pe_out_collector.sv
// tb_pe_out_collector: self-checking bench for pe_out_collector with a queue-based reference model.
module tb_pe_out_collector;
    import pe_out_collector_pkg::*;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_N;

    pe_out_collector_if bus ();

    pe_out_collector dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: two pipeline slots, result queue, tile position since last phase change.
    exp_t pipe1, pipe2;
    bit   p1v, p2v;
    exp_t mq[$];
    bit   m_ovf;
    bit   m_phase;
    int   m_pos;

    function automatic int model_result(int sum, int carry, int sh);
        int v;
        int r;
        v = (sum + carry) % (1 << HALF);
        if (v >= (1 << (HALF - 1))) v = v - (1 << HALF);
        if (sh == 0) r = v;
        else r = (v + (1 << (sh - 1))) >>> sh;
`ifdef COLLECT_SAT_EN
        if (r > (2 ** (OUT_W - 1)) - 1) r = (2 ** (OUT_W - 1)) - 1;
        if (r < -(2 ** (OUT_W - 1))) r = -(2 ** (OUT_W - 1));
`else
        r = r % (2 ** OUT_W);
        if (r < 0) r = r + (2 ** OUT_W);
        if (r >= 2 ** (OUT_W - 1)) r = r - (2 ** OUT_W);
`endif
        return r;
    endfunction

    // Drive one cycle of inputs, advance the model across the clock edge, settle #1 after it.
    task automatic tick(input bit v, input int sum, input int carry, input int sh,
                        input bit ph, input bit rdy);
        bit pop;
        bit push;
        bus.in_valid     = v;
        bus.in_c         = {carry[HALF-1:0], sum[HALF-1:0]};
        bus.in_shift     = sh[SHIFT_W-1:0];
        bus.in_propagate = ph;
        bus.out_ready    = rdy;
        @(posedge CLK);
        pop  = rdy && (mq.size() > 0);
        push = p2v && ((mq.size() < DEPTH) || pop);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(pipe2);
        else if (p2v) m_ovf = 1'b1;
        p2v   = p1v;
        pipe2 = pipe1;
        p1v   = v;
        if (v) begin
            if (ph != m_phase) begin
                m_pos   = 0;
                m_phase = ph;
            end
            pipe1.data = model_result(sum, carry, sh);
            pipe1.last = ((m_pos % ROWS) == ROWS - 1);
            m_pos++;
        end
        #1;
    endtask

    task automatic assert_reset();
        bus.in_valid     = 1'b0;
        bus.in_c         = '0;
        bus.in_shift     = '0;
        bus.in_propagate = 1'b0;
        bus.out_ready    = 1'b0;
        RST_N            = 1'b0;
        p1v = 0; p2v = 0; mq.delete(); m_ovf = 0; m_phase = 0; m_pos = 0;
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // Send one result, wait (bounded) for it at the head, then pop it.
    task automatic send_and_get(input int sum, input int carry, input int sh,
                                output logic signed [OUT_W-1:0] got, output int lat,
                                output bit found);
        found = 0;
        lat   = 0;
        got   = '0;
        tick(1, sum, carry, sh, 0, 1);
        lat = 1;
        while (!found && lat < 6) begin
            if (bus.out_valid === 1'b1) begin
                found = 1;
                got   = bus.out_data;
            end else begin
                tick(0, 0, 0, 0, 0, 1);
                lat++;
            end
        end
        tick(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        assert_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%0d want=0", bus.out_data); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b want=0", bus.out_last); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
        checks++; if (bus.level !== '0) begin errors++; $display("FAIL reset_level got=%0d want=0", bus.level); end
        release_reset();
        repeat (2) tick(0, 0, 0, 0, 0, 1);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_no_entry got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_latency();
        logic signed [OUT_W-1:0] got;
        int lat;
        bit found;
        send_and_get(100, 28, 4, got, lat, found);
        checks++; if (!found || got !== 8'sd8) begin errors++; $display("FAIL basic_128_sh4 got=%0d found=%0d want=8", got, found); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL latency got=%0d want=3", lat); end
        send_and_get(5, 0, 0, got, lat, found);
        checks++; if (!found || got !== 8'sd5) begin errors++; $display("FAIL shift0 got=%0d want=5", got); end
    endtask

    task automatic test_round();
        logic signed [OUT_W-1:0] got;
        int lat;
        bit found;
        send_and_get('h7FFDB, 0, 2, got, lat, found);
        checks++; if (!found || got !== -8'sd9) begin errors++; $display("FAIL round_neg got=%0d want=-9", got); end
        send_and_get(3, 0, 1, got, lat, found);
        checks++; if (!found || got !== 8'sd2) begin errors++; $display("FAIL round_half_up got=%0d want=2", got); end
        // Carry half wraps: carry=2^19-10, sum=20 -> v=10 -> (10+4)>>3 = 1
        send_and_get(20, (1 << HALF) - 10, 3, got, lat, found);
        checks++; if (!found || got !== 8'sd1) begin errors++; $display("FAIL carry_wrap got=%0d want=1", got); end
    endtask

    task automatic test_clip();
        logic signed [OUT_W-1:0] got;
        logic signed [OUT_W-1:0] want_p;
        logic signed [OUT_W-1:0] want_n;
        int lat;
        bit found;
`ifdef COLLECT_SAT_EN
        want_p = 8'sd127;
        want_n = -8'sd128;
`else
        want_p = 8'sh E8;
        want_n = 8'sh18;
`endif
        send_and_get(1000, 0, 0, got, lat, found);
        checks++; if (!found || got !== want_p) begin errors++; $display("FAIL clip_pos got=%0d want=%0d", got, want_p); end
        send_and_get((1 << HALF) - 1000, 0, 0, got, lat, found);
        checks++; if (!found || got !== want_n) begin errors++; $display("FAIL clip_neg got=%0d want=%0d", got, want_n); end
    endtask

    task automatic test_overflow();
        assert_reset();
        release_reset();
        for (int i = 0; i < 5; i++) tick(1, i + 1, 0, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0, 0, 0);
        checks++; if (bus.level !== LVL_W'(4)) begin errors++; $display("FAIL ovf_level got=%0d want=4", bus.level); end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", bus.ovf); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== OUT_W'(i + 1)) begin
                errors++;
                $display("FAIL drain_order idx=%0d got=%0d valid=%b want=%0d", i, bus.out_data, bus.out_valid, i + 1);
            end
            tick(0, 0, 0, 0, 0, 1);
        end
        checks++; if (bus.out_valid !== 1'b0 || bus.level !== '0) begin errors++; $display("FAIL drain_empty valid=%b level=%0d want 0/0", bus.out_valid, bus.level); end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", bus.ovf); end
    endtask

    task automatic test_tile();
        bit lasts[$];
        bit exp1[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        bit exp2[6] = '{0, 0, 0, 0, 0, 1};
        assert_reset();
        release_reset();
        for (int i = 0; i < 12; i++) begin
            tick(i < 8, i, 0, 0, 0, 1);
            if (bus.out_valid === 1'b1) lasts.push_back(bus.out_last);
        end
        checks++; if (lasts.size() != 8) begin errors++; $display("FAIL tile_count got=%0d want=8", lasts.size()); end
        for (int i = 0; i < 8 && i < lasts.size(); i++) begin
            checks++; if (lasts[i] != exp1[i]) begin errors++; $display("FAIL tile_last idx=%0d got=%0d want=%0d", i, lasts[i], exp1[i]); end
        end
        lasts.delete();
        for (int i = 0; i < 10; i++) begin
            tick(i < 6, i, 0, 0, (i >= 2), 1);
            if (bus.out_valid === 1'b1) lasts.push_back(bus.out_last);
        end
        checks++; if (lasts.size() != 6) begin errors++; $display("FAIL phase_count got=%0d want=6", lasts.size()); end
        for (int i = 0; i < 6 && i < lasts.size(); i++) begin
            checks++; if (lasts[i] != exp2[i]) begin errors++; $display("FAIL phase_last idx=%0d got=%0d want=%0d", i, lasts[i], exp2[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit lasts[$];
        assert_reset();
        release_reset();
        for (int i = 0; i < 5; i++) tick(1, 7, 0, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 1);
        checks++; if (bus.level !== LVL_W'(3) || bus.ovf !== 1'b1) begin errors++; $display("FAIL pre_reset level=%0d ovf=%b want 3/1", bus.level, bus.ovf); end
        #2;
        assert_reset();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.level !== '0) begin errors++; $display("FAIL async_rst_level got=%0d want=0", bus.level); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL async_rst_ovf got=%b want=0", bus.ovf); end
        release_reset();
        for (int i = 0; i < 8; i++) begin
            tick(i < 4, i, 0, 0, 0, 1);
            if (bus.out_valid === 1'b1) lasts.push_back(bus.out_last);
        end
        checks++;
        if (lasts.size() != 4 || lasts[0] || lasts[1] || lasts[2] || !lasts[3]) begin
            errors++;
            $display("FAIL post_reset_tile count=%0d want 4 with last only on 4th", lasts.size());
        end
    endtask

    task automatic test_back_to_back();
        int first;
        int last_idx;
        int seen;
        logic signed [OUT_W-1:0] e8;
        assert_reset();
        release_reset();
        first = -1; last_idx = -1; seen = 0;
        for (int i = 0; i < 16; i++) begin
            tick(i < 10, $urandom_range(0, (1 << HALF) - 1), $urandom_range(0, (1 << HALF) - 1),
                 $urandom_range(0, 15), 0, 1);
            if (bus.out_valid === 1'b1) begin
                seen++;
                if (first < 0) first = i;
                last_idx = i;
                e8 = (mq.size() > 0) ? OUT_W'(mq[0].data) : '0;
                checks++; if (bus.out_data !== e8) begin errors++; $display("FAIL b2b_data idx=%0d got=%0d want=%0d", i, bus.out_data, e8); end
            end
        end
        checks++; if (seen != 10 || first != 2 || last_idx - first != 9) begin errors++; $display("FAIL b2b_rate seen=%0d first=%0d last=%0d want 10/2/11", seen, first, last_idx); end
    endtask

    task automatic test_random();
        logic signed [OUT_W-1:0] e8;
        bit ph;
        assert_reset();
        release_reset();
        ph = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) ph = ~ph;
            tick($urandom_range(0, 9) < 7, $urandom_range(0, (1 << HALF) - 1),
                 $urandom_range(0, (1 << HALF) - 1), $urandom_range(0, 15), ph,
                 $urandom_range(0, 1) == 1);
            checks++; if (bus.out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b want=%0d", i, bus.out_valid, mq.size() > 0); end
            checks++; if (bus.level !== LVL_W'(mq.size())) begin errors++; $display("FAIL rnd_level cyc=%0d got=%0d want=%0d", i, bus.level, mq.size()); end
            checks++; if (bus.ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b want=%0d", i, bus.ovf, m_ovf); end
            if (mq.size() > 0) begin
                e8 = OUT_W'(mq[0].data);
                checks++; if (bus.out_data !== e8) begin errors++; $display("FAIL rnd_data cyc=%0d got=%0d want=%0d", i, bus.out_data, e8); end
                checks++; if (bus.out_last !== mq[0].last) begin errors++; $display("FAIL rnd_last cyc=%0d got=%b want=%0d", i, bus.out_last, mq[0].last); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_round();
        test_clip();
        test_overflow();
        test_tile();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
